// File: rtl/reg_wb_arbiter_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package reg_wb_arbiter_pkg;

    localparam int REG_ID_W = 5;
    localparam int DATA_W   = 32;

    localparam logic [REG_ID_W-1:0] REG_ZERO_ID = 5'd0;

    // B-side arbitration state: buffer empty, buffer waiting, buffer starving
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_STALL = 2'd2
    } state_t;

endpackage

// File: rtl/reg_wb_arbiter_hold_buf.sv
// One-entry id/value holding buffer for long-latency results.
// Latency: load visible on outputs the cycle after the loading edge.
// Backpressure: owner must only load while empty; drain frees the slot at the next edge.
module wb_hold_buf
    import reg_wb_arbiter_pkg::*;
(
    input  logic                clock,
    input  logic                reset_n,
    input  logic                load,
    input  logic                drain,
    input  logic [REG_ID_W-1:0] load_id,
    input  logic [DATA_W-1:0]   load_value,
    output logic                full,
    output logic [REG_ID_W-1:0] id,
    output logic [DATA_W-1:0]   value
);

    // Capture on load, free on drain; load and drain never coincide.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            full  <= 1'b0;
            id    <= '0;
            value <= '0;
        end else if (load) begin
            full  <= 1'b1;
            id    <= load_id;
            value <= load_value;
        end else if (drain) begin
            full  <= 1'b0;
        end
    end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Arbitrates the register-file write port: pipeline writeback (A) always wins, long-latency unit (B) drains from a 1-entry buffer.
// Latency: A written 1 cycle after request; B written at earliest 1 cycle after capture; outputs registered.
// Backpressure: lu_ready only when buffer empty; stall_req asks the pipeline to drop A after STARVE_LIMIT A grants. Optional: REG_WB_PENDING_EN adds pend_rs/pend_rt.
module reg_wb_arbiter
    import reg_wb_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        wb_valid,
    input  logic [4:0]  wb_id,
    input  logic [31:0] wb_value,
    input  logic        lu_valid,
    output logic        lu_ready,
    input  logic [4:0]  lu_id,
    input  logic [31:0] lu_value,
    output logic        stall_req,
    output logic        control_reg_write,
    output logic [4:0]  control_write_id,
`ifdef REG_WB_PENDING_EN
    input  logic [4:0]  rd_rs_id,
    input  logic [4:0]  rd_rt_id,
    output logic        pend_rs,
    output logic        pend_rt,
`endif
    output logic [31:0] reg_write_value
);

    localparam logic [CNT_W-1:0] LIMIT_C    = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] LIMIT_M1_C = CNT_W'(STARVE_LIMIT - 1);

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic                buf_full;
    logic [REG_ID_W-1:0] buf_id;
    logic [DATA_W-1:0]   buf_value;
    logic                lu_xfer;
    logic                grant_a;
    logic                grant_b;

    // No fall-through: ready depends only on state, so a drain cycle is a bubble for B.
    assign lu_ready = reset_n && (state == ST_IDLE);
    assign lu_xfer  = lu_valid && lu_ready;
    assign grant_a  = wb_valid;
    assign grant_b  = !wb_valid && buf_full;

    wb_hold_buf u_hold_buf (
        .clock      (clock),
        .reset_n    (reset_n),
        .load       (lu_xfer),
        .drain      (grant_b),
        .load_id    (lu_id),
        .load_value (lu_value),
        .full       (buf_full),
        .id         (buf_id),
        .value      (buf_value)
    );

`ifdef REG_WB_PENDING_EN
    // Flag decode operands whose producer result is parked but not yet written.
    always_comb begin
        pend_rs = buf_full && (buf_id == rd_rs_id) && (buf_id != REG_ZERO_ID);
        pend_rt = buf_full && (buf_id == rd_rt_id) && (buf_id != REG_ZERO_ID);
    end
`endif

    // Next-state and starvation count: count A grants while B waits, saturate at the limit.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: begin
                if (lu_xfer) begin
                    state_nxt = ST_WAIT;
                    cnt_nxt   = '0;
                end
            end
            ST_WAIT: begin
                if (grant_b) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else if (grant_a) begin
                    if (cnt >= LIMIT_M1_C) begin
                        cnt_nxt   = LIMIT_C;
                        state_nxt = ST_STALL;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
            ST_STALL: begin
                if (grant_b) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // State register; stall_req is registered so it is high exactly while in STALL.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            stall_req <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            stall_req <= (state_nxt == ST_STALL);
        end
    end

    // Registered write port; register 0 consumes the slot without asserting the enable.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            control_reg_write <= 1'b0;
            control_write_id  <= '0;
            reg_write_value   <= '0;
        end else if (grant_a) begin
            control_reg_write <= (wb_id != REG_ZERO_ID);
            control_write_id  <= wb_id;
            reg_write_value   <= wb_value;
        end else if (grant_b) begin
            control_reg_write <= (buf_id != REG_ZERO_ID);
            control_write_id  <= buf_id;
            reg_write_value   <= buf_value;
        end else begin
            control_reg_write <= 1'b0;
        end
    end

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Self-checking bench for reg_wb_arbiter: directed cases plus randomized traffic against a queue model.
// Latency: model predicts registered outputs one edge after the inputs that cause them.
// Backpressure: model tracks the B buffer as a queue of at most one entry.
module tb_reg_wb_arbiter;

    localparam int LIMIT = 4;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        wb_valid;
    logic [4:0]  wb_id;
    logic [31:0] wb_value;
    logic        lu_valid;
    logic        lu_ready;
    logic [4:0]  lu_id;
    logic [31:0] lu_value;
    logic        stall_req;
    logic        control_reg_write;
    logic [4:0]  control_write_id;
    logic [31:0] reg_write_value;
`ifdef REG_WB_PENDING_EN
    logic [4:0]  rd_rs_id = 5'd0;
    logic [4:0]  rd_rt_id = 5'd0;
    logic        pend_rs;
    logic        pend_rt;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    reg_wb_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(4)) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .wb_valid          (wb_valid),
        .wb_id             (wb_id),
        .wb_value          (wb_value),
        .lu_valid          (lu_valid),
        .lu_ready          (lu_ready),
        .lu_id             (lu_id),
        .lu_value          (lu_value),
        .stall_req         (stall_req),
        .control_reg_write (control_reg_write),
        .control_write_id  (control_write_id),
`ifdef REG_WB_PENDING_EN
        .rd_rs_id          (rd_rs_id),
        .rd_rt_id          (rd_rt_id),
        .pend_rs           (pend_rs),
        .pend_rt           (pend_rt),
`endif
        .reg_write_value   (reg_write_value)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: B buffer as a queue, starvation as a count of A grants seen while B waits.
    logic [36:0] q[$];
    logic [36:0] ent;
    int          starve = 0;
    logic        m_we   = 1'b0;
    logic [4:0]  m_id   = 5'd0;
    logic [31:0] m_val  = 32'd0;
    logic        m_stall = 1'b0;
    bit          was_empty;

    always @(posedge clock) begin
        if (!reset_n) begin
            q.delete();
            starve  = 0;
            m_we    = 1'b0;
            m_id    = 5'd0;
            m_val   = 32'd0;
            m_stall = 1'b0;
        end else begin
            was_empty = (q.size() == 0);
            if (wb_valid) begin
                m_we  = (wb_id != 5'd0);
                m_id  = wb_id;
                m_val = wb_value;
                if (!was_empty && starve < LIMIT) starve++;
            end else if (!was_empty) begin
                ent    = q.pop_front();
                m_id   = ent[36:32];
                m_val  = ent[31:0];
                m_we   = (m_id != 5'd0);
                starve = 0;
            end else begin
                m_we = 1'b0;
            end
            if (lu_valid && was_empty) begin
                q.push_back({lu_id, lu_value});
                starve = 0;
            end
            m_stall = (q.size() != 0) && (starve >= LIMIT);
        end
    end

    // Every negedge: DUT outputs must match the model.
    always @(negedge clock) begin
        chk("model_we",    32'(control_reg_write), 32'(m_we));
        chk("model_id",    32'(control_write_id),  32'(m_id));
        chk("model_value", reg_write_value,        m_val);
        chk("model_stall", 32'(stall_req),         32'(m_stall));
        chk("model_ready", 32'(lu_ready),          32'(reset_n && (q.size() == 0)));
    end

    task automatic drive(input logic wv, input logic [4:0] wid, input logic [31:0] wval,
                         input logic lv, input logic [4:0] lid, input logic [31:0] lval);
        wb_valid = wv; wb_id = wid; wb_value = wval;
        lu_valid = lv; lu_id = lid; lu_value = lval;
    endtask

    // Inputs change 1 time unit after negedge, well away from the active edge.
    task automatic next_cycle();
        @(negedge clock);
        #1;
    endtask

    int wb_p;

    initial begin
        reset_n = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h33);

        // Reset held two cycles with lu_valid high
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            chk("rst_ready", 32'(lu_ready), 32'd0);
            chk("rst_we",    32'(control_reg_write), 32'd0);
            chk("rst_id",    32'(control_write_id), 32'd0);
            chk("rst_value", reg_write_value, 32'd0);
            chk("rst_stall", 32'(stall_req), 32'd0);
        end
        #1;
        reset_n = 1'b1;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        @(negedge clock);
        chk("post_rst_ready", 32'(lu_ready), 32'd1);
        chk("post_rst_we",    32'(control_reg_write), 32'd0);
        #1;

        // A-only
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
        @(negedge clock);
        chk("a_we",    32'(control_reg_write), 32'd1);
        chk("a_id",    32'(control_write_id), 32'd5);
        chk("a_value", reg_write_value, 32'hDEADBEEF);
        #1;
        drive(1'b0, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
        @(negedge clock);
        chk("a_drop_we", 32'(control_reg_write), 32'd0);
        chk("a_hold_id", 32'(control_write_id), 32'd5);
        #1;

        // B drain
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h12345678);
        @(negedge clock);
        chk("b_ready_low", 32'(lu_ready), 32'd0);
        chk("b_cap_we",    32'(control_reg_write), 32'd0);
        #1;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        @(negedge clock);
        chk("b_we",       32'(control_reg_write), 32'd1);
        chk("b_id",       32'(control_write_id), 32'd9);
        chk("b_value",    reg_write_value, 32'h12345678);
        chk("b_ready_hi", 32'(lu_ready), 32'd1);
        #1;

        // Starvation: capture id 7 while A keeps winning
        drive(1'b1, 5'd1, 32'hA0, 1'b1, 5'd7, 32'h77);
        next_cycle();
`ifdef REG_WB_PENDING_EN
        rd_rs_id = 5'd7;
        rd_rt_id = 5'd3;
        #1;
        chk("pend_rs_hit",  32'(pend_rs), 32'd1);
        chk("pend_rt_miss", 32'(pend_rt), 32'd0);
`endif
        for (int k = 1; k <= LIMIT; k++) begin
            drive(1'b1, 5'(k + 1), 32'(k), 1'b0, 5'd0, 32'd0);
            @(negedge clock);
            chk("starve_stall", 32'(stall_req), (k == LIMIT) ? 32'd1 : 32'd0);
            #1;
        end
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        @(negedge clock);
        chk("starve_we",    32'(control_reg_write), 32'd1);
        chk("starve_id",    32'(control_write_id), 32'd7);
        chk("starve_value", reg_write_value, 32'h77);
        chk("starve_clear", 32'(stall_req), 32'd0);
        #1;

        // Register 0 from both sides
        drive(1'b1, 5'd0, 32'h1111, 1'b1, 5'd0, 32'h2222);
        @(negedge clock);
        chk("r0_a_we",    32'(control_reg_write), 32'd0);
        chk("r0_ready",   32'(lu_ready), 32'd0);
`ifdef REG_WB_PENDING_EN
        rd_rs_id = 5'd0;
        #1;
        chk("pend_rs_r0", 32'(pend_rs), 32'd0);
`endif
        #1;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        @(negedge clock);
        chk("r0_b_we",    32'(control_reg_write), 32'd0);
        chk("r0_freed",   32'(lu_ready), 32'd1);
        #1;

        // Randomized traffic with varying A pressure and occasional resets
        wb_p = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 100 == 0) begin
                case ($urandom_range(0, 3))
                    0: wb_p = 10;
                    1: wb_p = 50;
                    2: wb_p = 90;
                    default: wb_p = 100;
                endcase
            end
            reset_n = ($urandom_range(0, 249) != 0);
            drive(($urandom_range(0, 99) < wb_p), 5'($urandom_range(0, 31)), $urandom(),
                  ($urandom_range(0, 99) < 60), 5'($urandom_range(0, 31)), $urandom());
`ifdef REG_WB_PENDING_EN
            rd_rs_id = 5'($urandom_range(0, 31));
            rd_rt_id = 5'($urandom_range(0, 31));
`endif
            next_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
